// File: rtl/booth_r8_frozen_encoder.sv
// Radix-8 Booth encoder for a frozen weight x, plus a registered my / 3*my feed toward the multiplier.
// Define BOOTH_ENC_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
module booth_r8_frozen_encoder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUPS = (WIDTH >> 2) + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [WIDTH-1:0]  w_x,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_my,
  output logic [GROUPS-1:0] s,
  output logic [GROUPS-1:0] d,
  output logic [GROUPS-1:0] t,
  output logic [GROUPS-1:0] q,
  output logic [GROUPS-1:0] n,
  output logic [WIDTH-1:0]  my,
  output logic [WIDTH+1:0]  tmy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frozen
);

  localparam int unsigned XW = 3 * GROUPS;

  typedef enum logic [0:0] {StEmpty, StFrozen} state_e;
  state_e state_q, state_d;

  logic              w_accept, in_accept, drained;
  logic [GROUPS-1:0] enc_s, enc_d, enc_t, enc_q, enc_n;
  logic [XW:0]       xz;
  logic [3:0]        grp;
  logic [WIDTH-1:0]  my_d;
  logic [WIDTH+1:0]  tmy_d;
  logic              out_valid_d;

  function automatic logic [WIDTH+1:0] times3(input logic [WIDTH-1:0] v);
    logic [WIDTH+1:0] e;
    e = {{2{v[WIDTH-1]}}, v};
    return e + {e[WIDTH:0], 1'b0};
  endfunction

  assign frozen    = (state_q == StFrozen);
  assign w_ready   = drained;
  assign w_accept  = w_valid & w_ready;
  assign in_accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:  if (w_accept) state_d = StFrozen;
      StFrozen: state_d = StFrozen;
    endcase
  end

  // Sign-extended weight with the implicit x[-1]=0 appended at the bottom
  assign xz = {XW'(signed'(w_x)), 1'b0};

  always_comb begin
    enc_s = '0;
    enc_d = '0;
    enc_t = '0;
    enc_q = '0;
    enc_n = '0;
    grp   = '0;
    for (int i = 0; i < GROUPS; i++) begin
      grp      = xz[3*i +: 4];
      enc_n[i] = grp[3] & ~(&grp[2:0]);
      unique case (grp)
        4'b0001, 4'b0010, 4'b1101, 4'b1110: enc_s[i] = 1'b1;
        4'b0011, 4'b0100, 4'b1011, 4'b1100: enc_d[i] = 1'b1;
        4'b0101, 4'b0110, 4'b1001, 4'b1010: enc_t[i] = 1'b1;
        4'b0111, 4'b1000:                   enc_q[i] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StEmpty;
      s       <= '0;
      d       <= '0;
      t       <= '0;
      q       <= '0;
      n       <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        s <= enc_s;
        d <= enc_d;
        t <= enc_t;
        q <= enc_q;
        n <= enc_n;
      end
    end
  end

`ifdef BOOTH_ENC_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_my_q, skid_my_d;
  logic             in_ready_q, in_ready_d;

  assign drained  = ~out_valid & ~skid_valid_q;
  // Weight priority is the only combinational term; out_ready never reaches in_ready
  assign in_ready = in_ready_q & ~w_accept;

  always_comb begin
    my_d         = my;
    tmy_d        = tmy;
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid_q;
    skid_my_d    = skid_my_q;
    if (~out_valid | out_ready) begin
      if (skid_valid_q) begin
        my_d         = skid_my_q;
        tmy_d        = times3(skid_my_q);
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_accept) begin
        my_d        = in_my;
        tmy_d       = times3(in_my);
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      skid_valid_d = 1'b1;
      skid_my_d    = in_my;
    end
    in_ready_d = (state_d == StFrozen) & ~skid_valid_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      skid_valid_q <= 1'b0;
      skid_my_q    <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_my_q    <= skid_my_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign drained  = ~out_valid;
  assign in_ready = frozen & (~out_valid | out_ready) & ~w_accept;

  always_comb begin
    my_d        = my;
    tmy_d       = tmy;
    out_valid_d = out_valid;
    if (in_accept) begin
      my_d        = in_my;
      tmy_d       = times3(in_my);
      out_valid_d = 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      my        <= '0;
      tmy       <= '0;
      out_valid <= 1'b0;
    end else begin
      my        <= my_d;
      tmy       <= tmy_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
